// File: rtl/seq_divider_8by4_pkg.sv
// Shared arithmetic definitions for the divider, matching the multiplier's widths.
package seq_divider_8by4_pkg;

    localparam int unsigned DIVIDEND_W_DEF = 8;
    localparam int unsigned DIVISOR_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient reported for a zero divisor.
    localparam logic [DIVIDEND_W_DEF-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_8by4_div_step.sv
// One combinational restoring-division step: shift in a bit, subtract if it fits.
module seq_divider_8by4_div_step
    import seq_divider_8by4_pkg::*;
#(
    parameter int unsigned DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W:0]   prem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   prem_out,
    output logic                 q_bit
);

    localparam int unsigned PR_W = DIVISOR_W + 1;

    logic [PR_W-1:0] shifted;

    // The incoming remainder is always below the divisor, so its top bit is zero
    // and dropping it during the shift loses nothing.
    always_comb begin
        shifted = PR_W'({prem_in, bit_in});
        if (shifted >= PR_W'(divisor)) begin
            prem_out = shifted - PR_W'(divisor);
            q_bit    = 1'b1;
        end else begin
            prem_out = shifted;
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider_8by4.sv
// Sequential restoring divider: one quotient bit per clock behind a start/busy/done handshake.
module seq_divider_8by4
    import seq_divider_8by4_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned COUNT_W = $clog2(DIVIDEND_W);

    state_e                state_q, state_nxt;
    logic [DIVIDEND_W-1:0] shreg_q, shreg_nxt;
    logic [DIVISOR_W-1:0]  dvsr_q, dvsr_nxt;
    logic [DIVISOR_W:0]    prem_q, prem_nxt;
    logic [COUNT_W-1:0]    count_q, count_nxt;
    logic                  busy_nxt, done_nxt, dbz_nxt;
    logic [DIVIDEND_W-1:0] quo_nxt;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [DIVISOR_W:0]    step_prem;
    logic                  step_qbit;

    seq_divider_8by4_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .prem_in  (prem_q),
        .bit_in   (shreg_q[DIVIDEND_W-1]),
        .divisor  (dvsr_q),
        .prem_out (step_prem),
        .q_bit    (step_qbit)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            dvsr_q      <= '0;
            prem_q      <= '0;
            count_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            shreg_q     <= shreg_nxt;
            dvsr_q      <= dvsr_nxt;
            prem_q      <= prem_nxt;
            count_q     <= count_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            quotient    <= quo_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= dbz_nxt;
        end
    end

    // Next-state and datapath control; the shift register fills with quotient bits
    // from the bottom as dividend bits leave from the top.
    always_comb begin
        state_nxt = state_q;
        shreg_nxt = shreg_q;
        dvsr_nxt  = dvsr_q;
        prem_nxt  = prem_q;
        count_nxt = count_q;
        quo_nxt   = quotient;
        rem_nxt   = remainder;
        dbz_nxt   = div_by_zero;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quo_nxt   = DIVIDEND_W'(DBZ_QUOTIENT);
                        rem_nxt   = '0;
                        dbz_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        shreg_nxt = dividend;
                        dvsr_nxt  = divisor;
                        prem_nxt  = '0;
                        count_nxt = '0;
                        dbz_nxt   = 1'b0;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                shreg_nxt = {shreg_q[DIVIDEND_W-2:0], step_qbit};
                prem_nxt  = step_prem;
                count_nxt = count_q + COUNT_W'(1);
                if (count_q == COUNT_W'(DIVIDEND_W - 1)) begin
                    quo_nxt   = {shreg_q[DIVIDEND_W-2:0], step_qbit};
                    rem_nxt   = DIVISOR_W'(step_prem);
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Self-checking bench for seq_divider_8by4 against an arithmetic reference model.
module tb_seq_divider_8by4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider_8by4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result packed as {quotient, remainder, div_by_zero}.
    function automatic logic [12:0] ref_div(input int unsigned a, input int unsigned b);
        if (b == 0) return {8'hFF, 4'h0, 1'b1};
        return {8'(a / b), 4'(a % b), 1'b0};
    endfunction

    // Issue one request from an idle cycle; returns in the done cycle (or on timeout).
    task automatic run_op(input int unsigned a, input int unsigned b,
                          output int lat, output int busy_cyc, output bit timed_out);
        start    = 1'b1;
        dividend = 8'(a);
        divisor  = 4'(b);
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat = 0; busy_cyc = 0; timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cyc++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        dividend = 8'($urandom); divisor = 4'($urandom);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {busy, done, quotient, remainder, div_by_zero});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bc; bit to;
        run_op(200, 7, lat, bc, to);
        checks++;
        if (to || lat != 8) begin
            failures++;
            $display("FAIL basic_latency got=%0d timeout=%0d exp=8", lat, to);
        end
        checks++;
        if (bc != 9) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d exp=9", bc);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd28, 4'd4, 1'b0}) begin
            failures++;
            $display("FAIL basic_result got q=%0d r=%0d z=%0d exp q=28 r=4 z=0",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL basic_done_pulse got done=%0d busy=%0d exp 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc; bit to;
        run_op(255, 1, lat, bc, to);
        checks++;
        if (to || {quotient, remainder, div_by_zero} !== ref_div(255, 1)) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h timeout=%0d",
                     {quotient, remainder, div_by_zero}, ref_div(255, 1), to);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_gap got busy=%0d exp 0", busy);
        end
        run_op(0, 15, lat, bc, to);
        checks++;
        if (to || lat != 8 || {quotient, remainder, div_by_zero} !== ref_div(0, 15)) begin
            failures++;
            $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=8",
                     {quotient, remainder, div_by_zero}, lat, ref_div(0, 15));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero();
        int lat, bc; bit to;
        run_op(9, 0, lat, bc, to);
        checks++;
        if (to || lat != 0) begin
            failures++;
            $display("FAIL dbz_latency got=%0d timeout=%0d exp=0 edges after accept", lat, to);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'hFF, 4'h0, 1'b1}) begin
            failures++;
            $display("FAIL dbz_result got=%h exp=%h", {quotient, remainder, div_by_zero},
                     {8'hFF, 4'h0, 1'b1});
        end
        @(posedge clk); #1;
        run_op(20, 3, lat, bc, to);
        checks++;
        if (to || {quotient, remainder, div_by_zero} !== ref_div(20, 3)) begin
            failures++;
            $display("FAIL dbz_clear got=%h exp=%h", {quotient, remainder, div_by_zero}, ref_div(20, 3));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int lat;
        bit seen;
        start = 1'b1; dividend = 8'd100; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 3; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!seen || lat != 8) begin
            failures++;
            $display("FAIL ignore_latency got=%0d seen=%0d exp=8", lat, seen);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd33, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL ignore_result got q=%0d r=%0d exp q=33 r=1", quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat, bc; bit to;
        bit saw_done;
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'h0) begin
            failures++;
            $display("FAIL abort_async_clear got=%h exp=0", {busy, done, quotient, remainder, div_by_zero});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL abort_no_done got activity=1 exp 0");
        end
        run_op(200, 7, lat, bc, to);
        checks++;
        if (to || lat != 8 || {quotient, remainder, div_by_zero} !== {8'd28, 4'd4, 1'b0}) begin
            failures++;
            $display("FAIL abort_recover got=%h lat=%0d exp=%h lat=8",
                     {quotient, remainder, div_by_zero}, lat, {8'd28, 4'd4, 1'b0});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, bc; bit to;
        int unsigned a, b;
        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 15);
            run_op(a, b, lat, bc, to);
            checks++;
            if (to || lat != ((b == 0) ? 0 : 8) ||
                {quotient, remainder, div_by_zero} !== ref_div(a, b)) begin
                failures++;
                $display("FAIL random %0d/%0d got=%h lat=%0d exp=%h",
                         a, b, {quotient, remainder, div_by_zero}, lat, ref_div(a, b));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exhaustive();
        int lat, bc; bit to;
        int unsigned qq, rr;
        logic [7:0] prod;
        bit ok;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(a, b, lat, bc, to);
                checks++;
                if (to || {quotient, remainder, div_by_zero} !== ref_div(a, b)) begin
                    failures++;
                    $display("FAIL exhaustive %0d/%0d got=%h exp=%h timeout=%0d",
                             a, b, {quotient, remainder, div_by_zero}, ref_div(a, b), to);
                end
                if (b != 0) begin
                    qq = quotient;
                    rr = remainder;
                    ok = (qq * b + rr == a) && (rr < b);
                    if (qq < 16) begin
                        prod = 4'(qq) * 4'(b);
                        ok = ok && (32'(prod) + rr == a);
                    end
                    checks++;
                    if (!ok) begin
                        failures++;
                        $display("FAIL invariant %0d/%0d got q=%0d r=%0d", a, b, qq, rr);
                    end
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_start_ignored();
        test_reset_abort();
        test_random();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
